// File: rtl/eth_crc32_stream_check.sv
// Ethernet receive FCS checker: strips the 4-byte FCS through a short delay line,
// validates CRC-32 on every frame and keeps saturating good/bad frame counters.
module eth_crc32_stream_check #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_sof,
   input  logic             in_vld,
   input  logic [7:0]       in_data,
   input  logic             in_eof,
   output logic             in_rdy,
   output logic             out_sof,
   output logic             out_vld,
   output logic [7:0]       out_data,
   output logic             out_eof,
   input  logic             out_rdy,
   output logic             stat_vld,
   output logic             stat_ok,
   output logic             stat_runt,
   output logic [CNT_W-1:0] cnt_ok,
   output logic [CNT_W-1:0] cnt_bad
);

   localparam logic [31:0] POLY    = 32'hEDB88320;
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   logic [31:0]      r_crc;
   logic [2:0]       r_cnt;
   logic             r_active;
   logic             r_first;
   logic [7:0]       r_dl [0:3];
   logic             r_out_vld, r_out_sof, r_out_eof;
   logic [7:0]       r_out_data;
   logic             r_stat_vld, r_stat_ok, r_stat_runt;
   logic [CNT_W-1:0] r_cnt_ok, r_cnt_bad;

   logic        w_accept, w_take, w_pop, w_abort, w_fin, w_good, w_runt;
   logic [31:0] w_crc_next;
   logic [2:0]  w_cnt_base;
   logic [1:0]  w_bad_inc;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         x = x[0] ? ((x >> 1) ^ POLY) : (x >> 1);
      return x;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   always_comb begin
      in_rdy     = !r_out_vld || out_rdy;
      w_accept   = in_vld && in_rdy;
      // bytes outside a frame are swallowed without touching any state
      w_take     = w_accept && (in_sof || r_active);
      w_crc_next = crc_byte(in_sof ? 32'hFFFFFFFF : r_crc, in_data);
      w_cnt_base = in_sof ? 3'd0 : r_cnt;
      w_pop      = w_take && !in_sof && (r_cnt == 3'd4);
      w_abort    = w_accept && in_sof && r_active;
      w_fin      = w_take && in_eof;
      w_good     = w_fin && w_pop && (w_crc_next == RESIDUE);
      w_runt     = w_fin && !w_pop;
      // an abort and a new 1-byte runt can land on the same byte: both count as bad
      w_bad_inc  = {1'b0, w_fin && !w_good} + {1'b0, w_abort};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc       <= 32'hFFFFFFFF;
         r_cnt       <= 3'd0;
         r_active    <= 1'b0;
         r_first     <= 1'b0;
         for (int i = 0; i < 4; i++) r_dl[i] <= 8'h00;
         r_out_vld   <= 1'b0;
         r_out_sof   <= 1'b0;
         r_out_eof   <= 1'b0;
         r_out_data  <= 8'h00;
         r_stat_vld  <= 1'b0;
         r_stat_ok   <= 1'b0;
         r_stat_runt <= 1'b0;
         r_cnt_ok    <= '0;
         r_cnt_bad   <= '0;
      end else begin
         r_stat_vld  <= w_abort || w_fin;
         r_stat_ok   <= w_good;
         r_stat_runt <= w_runt;
         if (w_good) r_cnt_ok <= sat_add(r_cnt_ok, 2'd1);
         if (w_bad_inc != 2'd0) r_cnt_bad <= sat_add(r_cnt_bad, w_bad_inc);

         if (w_pop) begin
            r_out_vld  <= 1'b1;
            r_out_data <= r_dl[0];
            r_out_sof  <= r_first;
            r_out_eof  <= in_eof;
         end else if (out_rdy) begin
            r_out_vld  <= 1'b0;
            r_out_sof  <= 1'b0;
            r_out_eof  <= 1'b0;
         end

         if (w_take && in_sof) r_first <= 1'b1;
         else if (w_pop)       r_first <= 1'b0;

         if (w_take) begin
            r_crc   <= w_crc_next;
            r_dl[0] <= r_dl[1];
            r_dl[1] <= r_dl[2];
            r_dl[2] <= r_dl[3];
            r_dl[3] <= in_data;
            if (w_fin) begin
               r_cnt    <= 3'd0;
               r_active <= 1'b0;
            end else begin
               r_cnt    <= (w_cnt_base == 3'd4) ? 3'd4 : w_cnt_base + 3'd1;
               r_active <= 1'b1;
            end
         end
      end
   end

   assign out_vld   = r_out_vld;
   assign out_sof   = r_out_sof;
   assign out_eof   = r_out_eof;
   assign out_data  = r_out_data;
   assign stat_vld  = r_stat_vld;
   assign stat_ok   = r_stat_ok;
   assign stat_runt = r_stat_runt;
   assign cnt_ok    = r_cnt_ok;
   assign cnt_bad   = r_cnt_bad;

endmodule

// File: doc/eth_crc32_stream_check.md
ETH_CRC32_STREAM_CHECK -- requirements
Module: eth_crc32_stream_check

Interface
REQ-001 Parameter: CNT_W, 16, width of the good/bad frame counters.
REQ-002 clk  input  1  sole clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_sof  input  1  first byte of received frame (qualified by in_vld).
REQ-005 in_vld  input  1  input byte valid.
REQ-006 in_data  input  8  received byte (payload followed by 4-byte FCS, LSB-first on wire).
REQ-007 in_eof  input  1  last byte of frame, i.e. FCS byte 3 (qualified by in_vld).
REQ-008 in_rdy  output  1  input accept; byte transferred when in_vld && in_rdy.
REQ-009 out_sof  output  1  first payload byte of frame.
REQ-010 out_vld  output  1  output byte valid.
REQ-011 out_data  output  8  payload byte, FCS stripped.
REQ-012 out_eof  output  1  last payload byte.
REQ-013 out_rdy  input  1  downstream accept; byte transferred when out_vld && out_rdy.
REQ-014 stat_vld  output  1  one-cycle frame-status pulse.
REQ-015 stat_ok  output  1  FCS correct (valid with stat_vld).
REQ-016 stat_runt  output  1  frame shorter than 5 bytes (valid with stat_vld).
REQ-017 cnt_ok  output  CNT_W  count of good frames, saturating.
REQ-018 cnt_bad  output  CNT_W  count of bad/runt/aborted frames, saturating.

Function
REQ-019 CRC: reflected poly 0xEDB88320 (Ethernet 0x04C11DB7), init 0xFFFFFFFF, byte-wise combinational update, no ROM.
REQ-020 CRC runs over every accepted byte incl. FCS; frame good iff post-update register of the eof byte == 0xDEBB20E3.
REQ-021 in_rdy = !out_vld || out_rdy (combinational); no other stall source.
REQ-022 Output registers hold out_vld/out_data/out_sof/out_eof stable until out_rdy; out_vld clears after transfer with no new byte.
REQ-023 4-entry byte delay line plus fill count 0..4; accepted byte pushes in; if count==4 the oldest byte is popped into output registers in same cycle (latency: byte k appears on out one cycle after byte k+4 accepted).
REQ-024 Byte accepted with in_sof: CRC reset to 0xFFFFFFFF before update, count reset, frame-active set; first subsequently popped byte carries out_sof=1.
REQ-025 Byte accepted with in_eof and count==4: popped byte carries out_eof=1; next cycle stat_vld=1, stat_ok per REQ-020, stat_runt=0, simultaneously with out_vld of that byte.
REQ-026 in_eof with count<4 (frame <5 bytes): no output byte, stat_vld=1, stat_ok=0, stat_runt=1.
REQ-027 After eof: delay line (FCS) discarded, count=0, frame-active cleared.
REQ-028 in_sof while frame-active (abort): previous frame ends without out_eof, stat_vld=1 stat_ok=0 stat_runt=0, cnt_bad++, new frame starts per REQ-024.
REQ-029 Bytes with in_vld while not frame-active and no in_sof: accepted and dropped, no CRC/output/status effect.
REQ-030 in_sof and in_eof on same byte: 1-byte runt per REQ-026.
REQ-031 cnt_ok increments on stat_ok pulse, cnt_bad on other status pulses; both saturate at all-ones.

Reset
REQ-032 rst=1: out_vld/out_sof/out_eof/stat_vld/stat_ok/stat_runt=0, out_data=0x00, CRC=0xFFFFFFFF, count=0, frame-active=0, counters=0.
REQ-033 rst mid-frame discards the partial frame with no status pulse; in_rdy=1 in first cycle after reset.

Verification
REQ-034 Payload "123456789" (0x31..0x39) + FCS 26 39 F4 CB, out_rdy=1 -> out 0x31..0x39, sof on 0x31, eof on 0x39, stat_ok=1, cnt_ok=1.
REQ-035 Same frame with last FCS byte 0xCA -> identical payload out, stat_ok=0, stat_runt=0, cnt_bad=1.
REQ-036 Same good frame, out_rdy toggled 1/0 every cycle -> no byte lost/duplicated, out fields stable while stalled, stat_ok=1.
REQ-037 4-byte frame (sof..eof) -> no out_vld, stat_vld with stat_runt=1; then 1-byte sof+eof -> runt again, cnt_bad=2.
REQ-038 sof + 6 bytes, then new sof + good "123456789" frame -> abort status (ok=0), then good frame correct, cnt_bad=1 cnt_ok=1.
REQ-039 rst asserted after 3 bytes of a frame, then good frame -> no status for partial, good frame ok, counters cnt_ok=1 cnt_bad=0.
